// File: rtl/grn_pkg.sv
// Shared types for the GRN accelerator: CCI-P MMIO channel subset, HC CSR
// types, MMIO read address map, read pipeline stage struct and the read mux.
package grn_pkg;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [63:0]         data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic [8:0] tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef logic [31:0] t_hc_control;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_RUN   = 3'd1,
    WR_DRAIN = 3'd2,
    WR_DONE  = 3'd3,
    WR_ERROR = 3'd4
  } t_wr_state;

  // Byte addresses of the 64-bit MMIO registers
  localparam logic [17:0] ADDR_DFH      = 18'h000;
  localparam logic [17:0] ADDR_AFU_ID_L = 18'h008;
  localparam logic [17:0] ADDR_AFU_ID_H = 18'h010;
  localparam logic [17:0] ADDR_RSVD0    = 18'h018;
  localparam logic [17:0] ADDR_RSVD1    = 18'h020;
  localparam logic [17:0] ADDR_DSM_BASE = 18'h110;
  localparam logic [17:0] ADDR_CONTROL  = 18'h118;
  localparam logic [17:0] ADDR_BUF_ADDR = 18'h120;
  localparam logic [17:0] ADDR_BUF_SIZE = 18'h128;
  localparam logic [17:0] ADDR_STATUS   = 18'h130;
  localparam logic [17:0] ADDR_RD_COUNT = 18'h138;
  localparam logic [17:0] ADDR_SCRATCH  = 18'h140;

  typedef struct packed {
    logic [8:0]  tid;
    logic [15:0] address;
    logic [1:0]  length;
    logic        valid;
  } t_rd_stage1;

  function automatic logic [63:0] rd_mux(
    input logic [17:0] byte_addr,
    input logic [63:0] dfh,
    input logic [63:0] afu_id_l,
    input logic [63:0] afu_id_h,
    input logic [63:0] dsm_base,
    input t_hc_control control,
    input t_hc_buffer  buffer,
    input logic [31:0] status,
    input logic [31:0] rd_count,
    input logic [63:0] scratch
  );
    logic [63:0] val;
    case (byte_addr)
      ADDR_DFH:      val = dfh;
      ADDR_AFU_ID_L: val = afu_id_l;
      ADDR_AFU_ID_H: val = afu_id_h;
      ADDR_RSVD0:    val = 64'h0;
      ADDR_RSVD1:    val = 64'h0;
      ADDR_DSM_BASE: val = dsm_base;
      ADDR_CONTROL:  val = {32'h0, control};
      ADDR_BUF_ADDR: val = buffer.address;
      ADDR_BUF_SIZE: val = {32'h0, buffer.size};
      ADDR_STATUS:   val = {32'h0, status};
      ADDR_RD_COUNT: val = {32'h0, rd_count};
      ADDR_SCRATCH:  val = scratch;
      default:       val = 64'h0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/grn_mmio_rd.sv
// GRN MMIO read responder: two-stage pipelined CSR read path with a read counter.
// Optional 64-bit scratch register at 0x140 when GRN_MMIO_SCRATCH_EN is defined.
module grn_mmio_rd
  import grn_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L  = 64'h0,
  parameter logic [63:0] AFU_ID_H  = 64'h0,
  parameter logic [63:0] DFH_VALUE = 64'h1000_0000_0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  t_if_ccip_c0_Rx rx_mmio,
  output t_if_ccip_c2_Tx tx_mmio,
  input  logic [63:0]    dsm_base,
  input  t_hc_control    control,
  input  t_hc_buffer     buffer,
  input  logic [31:0]    status
);

  t_rd_stage1  s1;
  logic [31:0] rd_count;
  logic [63:0] scratch;
  logic [17:0] rd_byte_addr;
  logic [63:0] reg_data;
  logic [63:0] rsp_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.valid   <= rx_mmio.mmioRdValid;
      s1.tid     <= rx_mmio.hdr.tid;
      s1.address <= rx_mmio.hdr.address;
      s1.length  <= rx_mmio.hdr.length;
    end
  end

  // CSRs are sampled here, so the counter bumps on the stage-1 edge and a
  // read of 0x138 sees its own pre-increment value.
  always_comb begin
    rd_byte_addr = {s1.address[15:1], 3'b000};
    reg_data = rd_mux(rd_byte_addr, DFH_VALUE, AFU_ID_L, AFU_ID_H, dsm_base,
                      control, buffer, status, rd_count, scratch);
    if (s1.length == 2'd0) begin
      rsp_data = {32'h0, (s1.address[0] ? reg_data[63:32] : reg_data[31:0])};
    end else begin
      rsp_data = reg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_mmio <= '0;
    end else begin
      tx_mmio.mmioRdValid <= s1.valid;
      if (s1.valid) begin
        tx_mmio.hdr.tid <= s1.tid;
        tx_mmio.data    <= rsp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= 32'h0;
    end else if (s1.valid) begin
      rd_count <= rd_count + 32'd1;
    end
  end

`ifdef GRN_MMIO_SCRATCH_EN
  logic scratch_wr;
  logic unused_rx_bits;

  assign scratch_wr = rx_mmio.mmioWrValid && (rx_mmio.hdr.length == 2'd1) &&
                      ({rx_mmio.hdr.address, 2'b00} == ADDR_SCRATCH);

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch <= 64'h0;
    end else if (scratch_wr) begin
      scratch <= rx_mmio.data;
    end
  end

  assign unused_rx_bits = ^{rx_mmio.hdr.rsvd, rx_mmio.rspValid};
`else
  logic unused_rx_bits;

  assign scratch = 64'h0;
  assign unused_rx_bits = ^{rx_mmio.hdr.rsvd, rx_mmio.rspValid,
                            rx_mmio.mmioWrValid, rx_mmio.data};
`endif

endmodule

// File: tb/tb_grn_mmio_rd.sv
// Directed self-checking bench for grn_mmio_rd; expectations are hand-computed
// from the register map and CSR values driven below.
module tb_grn_mmio_rd;
  import grn_pkg::*;

  localparam logic [63:0] AFU_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] AFU_H = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DFH   = 64'h1000_0000_0000_0000;

  logic           clk = 1'b0;
  logic           reset;
  t_if_ccip_c0_Rx rx_mmio;
  t_if_ccip_c2_Tx tx_mmio;
  logic [63:0]    dsm_base;
  t_hc_control    control;
  t_hc_buffer     buffer;
  logic [31:0]    status;

  int checks = 0;
  int errors = 0;
  logic [63:0] scratch_exp;

  always #5 clk = ~clk;

  grn_mmio_rd #(
    .AFU_ID_L (AFU_L),
    .AFU_ID_H (AFU_H),
    .DFH_VALUE(DFH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_mmio (rx_mmio),
    .tx_mmio (tx_mmio),
    .dsm_base(dsm_base),
    .control (control),
    .buffer  (buffer),
    .status  (status)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic rsp,
                               input logic [15:0] word, input logic [1:0] len,
                               input logic [8:0] tid, input logic [63:0] wdata);
    rx_mmio             = '0;
    rx_mmio.mmioRdValid = rd;
    rx_mmio.mmioWrValid = wr;
    rx_mmio.rspValid    = rsp;
    rx_mmio.hdr.address = word;
    rx_mmio.hdr.length  = len;
    rx_mmio.hdr.tid     = tid;
    rx_mmio.data        = wdata;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic exp_valid,
                             input logic [8:0] exp_tid, input logic [63:0] exp_data);
    checkValue({tag, ".valid"}, {63'h0, tx_mmio.mmioRdValid}, {63'h0, exp_valid});
    if (exp_valid) begin
      checkValue({tag, ".tid"}, {55'h0, tx_mmio.hdr.tid}, {55'h0, exp_tid});
      checkValue({tag, ".data"}, tx_mmio.data, exp_data);
    end
  endtask

  task automatic doRead(input string tag, input logic [15:0] word, input logic [1:0] len,
                        input logic [8:0] tid, input logic [63:0] exp);
    applyStimulus(1'b1, 1'b0, 1'b0, word, len, tid, 64'h0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    checkOutput({tag, ".early"}, 1'b0, 9'h0, 64'h0);
    step();
    checkOutput(tag, 1'b1, tid, exp);
  endtask

  initial begin
`ifdef GRN_MMIO_SCRATCH_EN
    scratch_exp = 64'h1234;
`else
    scratch_exp = 64'h0;
`endif
    reset          = 1'b1;
    dsm_base       = 64'hAAAA_BBBB_CCCC_DDDD;
    control        = 32'h0000_00A5;
    buffer.address = 64'hDEAD_BEEF_0123_4567;
    buffer.size    = 32'h0000_2000;
    status         = 32'h1234_5003;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    step();
    step();
    reset = 1'b0;
    checkOutput("reset", 1'b0, 9'h0, 64'h0);
    checkValue("reset.tid", {55'h0, tx_mmio.hdr.tid}, 64'h0);
    checkValue("reset.data", tx_mmio.data, 64'h0);

    doRead("rdcnt_first", 16'h4E, 2'd1, 9'h07, 64'h0);
    doRead("dfh", 16'h00, 2'd1, 9'h05, DFH);
    step();
    checkOutput("dfh_hold", 1'b0, 9'h0, 64'h0);
    checkValue("dfh_hold.data", tx_mmio.data, DFH);
    checkValue("dfh_hold.tid", {55'h0, tx_mmio.hdr.tid}, 64'h5);

    doRead("afu_id_l", 16'h02, 2'd1, 9'h06, AFU_L);
    doRead("afu_id_h", 16'h04, 2'd1, 9'h08, AFU_H);
    doRead("buf_lo32", 16'h48, 2'd0, 9'h11, 64'h0000_0000_0123_4567);
    doRead("buf_hi32", 16'h49, 2'd0, 9'h12, 64'h0000_0000_DEAD_BEEF);
    doRead("buf_odd8b", 16'h49, 2'd1, 9'h13, 64'hDEAD_BEEF_0123_4567);
    doRead("buf_size", 16'h4A, 2'd1, 9'h14, 64'h0000_0000_0000_2000);
    doRead("ctrl_lo32", 16'h46, 2'd0, 9'h15, 64'h0000_0000_0000_00A5);
    doRead("ctrl_hi32", 16'h47, 2'd0, 9'h16, 64'h0);
    doRead("rsvd_018", 16'h06, 2'd1, 9'h17, 64'h0);
    doRead("word_100", 16'h100, 2'd1, 9'h18, 64'h0);
    doRead("word_101_4b", 16'h101, 2'd0, 9'h19, 64'h0);

    // Back-to-back reads: one response per cycle, in order
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h44, 2'd1, 9'd1, 64'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h46, 2'd1, 9'd2, 64'h0);
    step();
    checkOutput("b2b_110", 1'b1, 9'd1, 64'hAAAA_BBBB_CCCC_DDDD);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4C, 2'd1, 9'd3, 64'h0);
    step();
    checkOutput("b2b_118", 1'b1, 9'd2, 64'h0000_0000_0000_00A5);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'hFE, 2'd1, 9'd4, 64'h0);
    step();
    checkOutput("b2b_130", 1'b1, 9'd3, 64'h0000_0000_1234_5003);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    step();
    checkOutput("b2b_3f8", 1'b1, 9'd4, 64'h0);
    step();
    checkOutput("b2b_idle", 1'b0, 9'h0, 64'h0);

    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00, 2'd1, 9'h20, 64'h5555);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    step();
    checkOutput("ignore_wr_rsp", 1'b0, 9'h0, 64'h0);
    step();
    checkOutput("ignore_wr_rsp2", 1'b0, 9'h0, 64'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h50, 2'd1, 9'h21, 64'h1234);
    step();
    doRead("scratch", 16'h50, 2'd1, 9'h22, scratch_exp);
    doRead("scratch_hi32", 16'h51, 2'd0, 9'h23, 64'h0);

    // Counter wrap: preload all-ones, then two back-to-back reads of 0x138
    force dut.rd_count = 32'hFFFF_FFFF;
    step();
    release dut.rd_count;
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4E, 2'd1, 9'h0A, 64'h0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4E, 2'd1, 9'h0B, 64'h0);
    step();
    checkOutput("rdcnt_max", 1'b1, 9'h0A, 64'h0000_0000_FFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    step();
    checkOutput("rdcnt_wrap", 1'b1, 9'h0B, 64'h0);

    // Reset one cycle after a read: it and the read presented during reset vanish
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h00, 2'd1, 9'h0C, 64'h0);
    step();
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h4E, 2'd1, 9'h0D, 64'h0);
    step();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 9'h0, 64'h0);
    checkOutput("midrst_n2", 1'b0, 9'h0, 64'h0);
    checkValue("midrst.tid", {55'h0, tx_mmio.hdr.tid}, 64'h0);
    checkValue("midrst.data", tx_mmio.data, 64'h0);
    step();
    checkOutput("midrst_n3", 1'b0, 9'h0, 64'h0);
    doRead("rdcnt_after_rst", 16'h4E, 2'd1, 9'h0E, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grn_mmio_rd.md
GRN_MMIO_RD -- requirements
Module: grn_mmio_rd

Interface
REQ-001 SHALL have parameter AFU_ID_L, default 64'h0, meaning low 64 bits of the AFU UUID.
REQ-002 SHALL have parameter AFU_ID_H, default 64'h0, meaning high 64 bits of the AFU UUID.
REQ-003 SHALL have parameter DFH_VALUE, default 64'h1000_0000_0000_0000 (AFU type, EOL clear), meaning the device feature header word.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port rx_mmio, input, t_if_ccip_c0_Rx, the host MMIO request channel; only mmioRdValid is consumed.
REQ-007 SHALL have port tx_mmio, output, t_if_ccip_c2_Tx, the MMIO read response channel.
REQ-008 SHALL have port dsm_base, input, 64, current DSM base CSR value.
REQ-009 SHALL have port control, input, t_hc_control (32), current HC_CONTROL value.
REQ-010 SHALL have port buffer, input, t_hc_buffer, current buffer address/size CSR values.
REQ-011 SHALL have port status, input, 32, accelerator status word; bits [2:0] carry the t_wr_state encoding.

Function
REQ-012 SHALL decode the request byte address as hdr.address<<2; hdr.tid SHALL be carried unchanged to the response.
REQ-013 SHALL map 64-bit registers: 0x000 DFH_VALUE, 0x008 AFU_ID_L, 0x010 AFU_ID_H, 0x018 zero, 0x020 zero, 0x110 dsm_base, 0x118 {32'h0, control}, 0x120 buffer.address, 0x128 {32'h0, buffer.size}, 0x130 {32'h0, status}, 0x138 {32'h0, rd_count}.
REQ-014 SHALL return 64'h0 for every unmapped address, including any word address >= 'h100.
REQ-015 SHALL, for hdr.length = 0 (4 B), return the upper 32 bits of the register in data[31:0] when address bit 0 is 1 and the lower 32 bits when it is 0; data[63:32] SHALL be 0.
REQ-016 SHALL, for hdr.length = 1 (8 B), return the full 64-bit register, using the address with bit 0 ignored.
REQ-017 SHALL use a two-stage pipeline: stage 1 registers tid/address/length; stage 2 registers the muxed data and asserts tx_mmio.mmioRdValid exactly 2 cycles after the request cycle.
REQ-018 SHALL accept one read per cycle with no stall; back-to-back reads SHALL produce back-to-back responses, in order.
REQ-019 SHALL sample the CSR inputs in the stage-1 cycle (request cycle + 1).
REQ-020 SHALL keep a 32-bit rd_count that increments by 1 per accepted read and wraps 32'hFFFF_FFFF -> 0; a read of 0x138 SHALL return the value before its own increment.
REQ-021 SHALL ignore mmioWrValid and every c0 response type other than an MMIO read.
REQ-022 SHALL hold tx_mmio.data and hdr at their last values while mmioRdValid is 0.

Reset
REQ-023 SHALL, on reset, clear both pipeline valid bits, tx_mmio.mmioRdValid, tx_mmio.hdr, tx_mmio.data and rd_count to 0 on the next edge.
REQ-024 SHALL discard reads in flight when reset asserts mid-pipeline; no response SHALL be issued for them.
REQ-025 SHALL ignore a request presented in a cycle where reset is high.

Configuration
REQ-026 SHALL, when GRN_MMIO_SCRATCH_EN is defined, add a 64-bit scratch register at 0x140, written by 8 B MMIO writes to that address, read back per REQ-015/016, and reset to 0.
REQ-027 SHALL, when GRN_MMIO_SCRATCH_EN is undefined, contain no scratch logic, and 0x140 SHALL read as 0.

Structure
REQ-028 SHALL place the read address constants (0x000-0x140) and the stage-1 pipeline struct (tid, address, length, valid) in grn_pkg next to the HC definitions.
REQ-029 SHALL be a single module with no sub-module; the read mux SHALL be a package function taking the byte address.

Verification
REQ-030 SHALL verify the DFH read: read of 0x000, length 1, tid 9'h05 -> 2 cycles later mmioRdValid=1, tid 9'h05, data=DFH_VALUE.
REQ-031 SHALL verify 4 B halves: buffer.address=64'hDEAD_BEEF_0123_4567; 4 B reads at word 0x48 and word 0x49 -> data 32'h0123_4567, then 32'hDEAD_BEEF.
REQ-032 SHALL verify back-to-back reads: 4 consecutive 8 B reads of 0x110, 0x118, 0x130, 0x3F8 with tids 1-4 -> 4 consecutive responses in order; 0x3F8 returns 0.
REQ-033 SHALL verify rd_count and wrap: preload 32'hFFFF_FFFF via 0xFFFF_FFFF reads (or force), read 0x138 -> FFFF_FFFF, then read 0x138 -> 0.
REQ-034 SHALL verify reset mid-flight: read issued in cycle N, reset asserted in cycle N+1 -> no mmioRdValid in cycles N+2 and N+3, rd_count = 0.
REQ-035 SHALL verify GRN_MMIO_SCRATCH_EN: write 64'h1234 to 0x140, then read -> 64'h1234 when defined, 0 when undefined.
